// File: rtl/cog_seq.sv
// Cog instruction sequencer: fetch, condition evaluation, S/D operand read,
// hub-op stall and commit of result, flags and next PC for the cog ALU.
module cog_seq #(
  parameter logic [8:0] PC_RESET = 9'h000
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        ena,
  output logic [8:0]  m_ra,
  input  logic [31:0] m_rq,
  output logic        m_we,
  output logic [8:0]  m_wa,
  output logic [31:0] m_wd,
  output logic [5:0]  alu_i,
  output logic [31:0] alu_s,
  output logic [31:0] alu_d,
  output logic [8:0]  alu_p,
  output logic        alu_run,
  output logic        alu_ci,
  output logic        alu_zi,
  output logic        alu_wc,
  input  logic        alu_wr,
  input  logic        alu_co,
  input  logic        alu_zo,
  input  logic [31:0] alu_r,
  output logic        hub_req,
  input  logic        hub_ack,
  output logic [8:0]  pc,
  output logic        c,
  output logic        z
);

  typedef enum logic [2:0] {IDLE, FI, FS, FD, EX, AL} state_t;

  localparam logic [5:0] OP_JMPRET = 6'b010111;
  localparam logic [5:0] OP_DJNZ   = 6'b111001;
  localparam logic [5:0] OP_TJNZ   = 6'b111010;
  localparam logic [5:0] OP_TJZ    = 6'b111011;

  state_t      state_q, state_d;
  logic [8:0]  pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] s_q, s_d;
  logic [31:0] d_q, d_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic        run_q, run_d;

  logic [5:0]  op;
  logic [3:0]  cond;
  logic        cond_ok;
  logic        is_hub;
  logic        stall;
  logic        take_jmp;

  assign op      = ir_q[31:26];
  assign cond    = ir_q[21:18];
  assign cond_ok = cond[{c_q, z_q}];
  // 00010x are cog-local ops living in the hub opcode group
  assign is_hub  = (op[5:3] == 3'b000) && (op[5:1] != 5'b00010);
  assign hub_req = (state_q == AL) && cond_ok && is_hub;
  assign stall   = hub_req && !hub_ack;

  assign take_jmp = cond_ok &&
                    ((op == OP_JMPRET) ||
                     ((op == OP_DJNZ) && (alu_r != 32'd0)) ||
                     ((op == OP_TJNZ) && (d_q != 32'd0)) ||
                     ((op == OP_TJZ)  && (d_q == 32'd0)));

  assign alu_i   = ir_q[31:26];
  assign alu_s   = s_q;
  assign alu_d   = d_q;
  assign alu_p   = pc_q + 9'd1;
  assign alu_run = run_q;
  assign alu_ci  = c_q;
  assign alu_zi  = z_q;
  assign alu_wc  = ir_q[24];
  assign pc      = pc_q;
  assign c       = c_q;
  assign z       = z_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    s_d     = s_q;
    d_d     = d_q;
    c_d     = c_q;
    z_d     = z_q;
    run_d   = run_q;
    m_ra    = 9'd0;
    m_we    = 1'b0;
    m_wa    = 9'd0;
    m_wd    = 32'd0;
    case (state_q)
      IDLE: state_d = FI;
      FI: begin
        m_ra    = pc_q;
        run_d   = 1'b1;
        state_d = FS;
      end
      FS: begin
        ir_d    = m_rq;
        m_ra    = m_rq[8:0];
        state_d = FD;
      end
      FD: begin
        m_ra    = ir_q[17:9];
        s_d     = ir_q[22] ? {23'd0, ir_q[8:0]} : m_rq;
        state_d = EX;
      end
      EX: begin
        d_d     = m_rq;
        state_d = AL;
      end
      AL: begin
        if (!stall) begin
          state_d = FI;
          pc_d    = take_jmp ? s_q[8:0] : pc_q + 9'd1;
          if (cond_ok) begin
            m_we = ir_q[23] & alu_wr;
            m_wa = ir_q[17:9];
            m_wd = alu_r;
            if (ir_q[24]) c_d = alu_co;
            if (ir_q[25]) z_d = alu_zo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable wins over everything, including a commit in flight
    if (!ena) begin
      state_d = IDLE;
      pc_d    = PC_RESET;
      run_d   = 1'b0;
      m_we    = 1'b0;
      c_d     = c_q;
      z_d     = z_q;
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= 32'd0;
      s_q     <= 32'd0;
      d_q     <= 32'd0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      s_q     <= s_d;
      d_q     <= d_d;
      c_q     <= c_d;
      z_q     <= z_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_cog_seq.sv
// Bench for cog_seq: cog RAM and ALU models around the DUT, write scoreboard,
// directed programs covering conditions, jumps, PC wrap, hub stall and disable.
module tb_cog_seq;

  localparam logic [5:0]  OP_ADD    = 6'b100000;
  localparam logic [5:0]  OP_SUB    = 6'b100001;
  localparam logic [5:0]  OP_MOV    = 6'b101000;
  localparam logic [5:0]  OP_JMPRET = 6'b010111;
  localparam logic [5:0]  OP_DJNZ   = 6'b111001;
  localparam logic [5:0]  OP_TJNZ   = 6'b111010;
  localparam logic [5:0]  OP_TJZ    = 6'b111011;
  localparam logic [5:0]  OP_RDLONG = 6'b000010;
  localparam logic [31:0] HUB_DATA  = 32'hCAFE0000;

  logic        clk_cog = 1'b0;
  logic        nres = 1'b0;
  logic        ena = 1'b0;
  logic [8:0]  m_ra;
  logic [31:0] m_rq = 32'd0;
  logic        m_we;
  logic [8:0]  m_wa;
  logic [31:0] m_wd;
  logic [5:0]  alu_i;
  logic [31:0] alu_s, alu_d;
  logic [8:0]  alu_p;
  logic        alu_run, alu_ci, alu_zi, alu_wc;
  logic        alu_wr, alu_co, alu_zo;
  logic [31:0] alu_r;
  logic        hub_req;
  logic        hub_ack = 1'b0;
  logic [8:0]  pc;
  logic        c, z;

  cog_seq #(.PC_RESET(9'h000)) dut (
    .clk_cog(clk_cog), .nres(nres), .ena(ena),
    .m_ra(m_ra), .m_rq(m_rq), .m_we(m_we), .m_wa(m_wa), .m_wd(m_wd),
    .alu_i(alu_i), .alu_s(alu_s), .alu_d(alu_d), .alu_p(alu_p),
    .alu_run(alu_run), .alu_ci(alu_ci), .alu_zi(alu_zi), .alu_wc(alu_wc),
    .alu_wr(alu_wr), .alu_co(alu_co), .alu_zo(alu_zo), .alu_r(alu_r),
    .hub_req(hub_req), .hub_ack(hub_ack), .pc(pc), .c(c), .z(z)
  );

  always #5 clk_cog = ~clk_cog;

  // Cog RAM: registered read, preload port used while the DUT is idle
  logic [31:0] mem [0:511];
  logic        pl_we = 1'b0;
  logic [8:0]  pl_a = 9'd0;
  logic [31:0] pl_d = 32'd0;
  always @(posedge clk_cog) begin
    if (pl_we)     mem[pl_a] <= pl_d;
    else if (m_we) mem[m_wa] <= m_wd;
    m_rq <= mem[m_ra];
  end

  // Reference ALU
  always_comb begin
    alu_r  = 32'd0;
    alu_co = 1'b0;
    alu_wr = 1'b0;
    case (alu_i)
      OP_ADD:    begin {alu_co, alu_r} = {1'b0, alu_d} + {1'b0, alu_s}; alu_wr = 1'b1; end
      OP_SUB:    begin {alu_co, alu_r} = {1'b0, alu_d} - {1'b0, alu_s}; alu_wr = 1'b1; end
      OP_MOV:    begin alu_r = alu_s; alu_wr = 1'b1; end
      OP_JMPRET: begin alu_r = {alu_d[31:9], alu_p}; alu_wr = 1'b1; end
      OP_DJNZ:   begin alu_r = alu_d - 32'd1; alu_wr = 1'b1; end
      OP_TJZ, OP_TJNZ: alu_r = alu_d;
      OP_RDLONG: begin alu_r = HUB_DATA; alu_wr = 1'b1; end
      default: ;
    endcase
  end
  assign alu_zo = (alu_r == 32'd0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [8:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t sbq[$];

  task automatic push(input logic [8:0] wa, input logic [31:0] wd);
    wr_t e;
    e.wa = wa;
    e.wd = wd;
    sbq.push_back(e);
  endtask

  // Every RAM write strobe must match the next expected write
  always begin : mon
    wr_t e;
    @(negedge clk_cog);
    #2;
    if (nres && m_we) begin
      if (sbq.size() == 0) chk("we_unexp", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("wr_addr", {23'd0, m_wa}, {23'd0, e.wa});
        chk("wr_data", m_wd, e.wd);
      end
    end
  end

  function automatic logic [31:0] ins(input logic [5:0] op, input logic wz, input logic wc,
                                      input logic wr, input logic im, input logic [3:0] cnd,
                                      input logic [8:0] dst, input logic [8:0] src);
    return {op, wz, wc, wr, im, cnd, dst, src};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_cog);
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    tick(1);
    pl_we = 1'b0;
  endtask

  task automatic start_run();
    nres    = 1'b0;
    ena     = 1'b0;
    hub_ack = 1'b0;
    tick(2);
    nres = 1'b1;
    tick(1);
    ena = 1'b1;
  endtask

  logic [8:0] exp_pc_a [0:10];
  logic       exp_c_a  [0:10];
  logic [8:0] exp_pc_b [0:2];
  logic       exp_z_b  [0:2];
  int         cyc, cnt;

  initial begin
    exp_pc_a = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h1FF, 9'h010, 9'h020, 9'h030, 9'h031, 9'h040};
    exp_c_a  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_pc_b = '{9'h1FF, 9'h000, 9'h001};
    exp_z_b  = '{1'b0, 1'b1, 1'b1};

    // ---------------- program A: ALU ops, conditions, jumps
    load(9'h000, ins(OP_ADD,    0, 0, 1, 0, 4'hF,    9'h100, 9'h101));
    load(9'h001, ins(OP_ADD,    0, 1, 1, 1, 4'hF,    9'h102, 9'h1FF));
    load(9'h002, ins(OP_SUB,    1, 1, 1, 0, 4'hF,    9'h103, 9'h104));
    load(9'h003, ins(OP_MOV,    1, 1, 1, 0, 4'b0000, 9'h105, 9'h106));
    load(9'h004, ins(OP_MOV,    0, 0, 1, 0, 4'b0100, 9'h107, 9'h108));
    load(9'h005, ins(OP_JMPRET, 0, 0, 1, 1, 4'hF,    9'h109, 9'h1FF));
    load(9'h1FF, ins(OP_JMPRET, 0, 0, 1, 1, 4'hF,    9'h10A, 9'h010));
    load(9'h010, ins(OP_DJNZ,   0, 0, 1, 1, 4'hF,    9'h10B, 9'h020));
    load(9'h020, ins(OP_TJZ,    0, 0, 0, 1, 4'hF,    9'h10C, 9'h030));
    load(9'h030, ins(OP_TJNZ,   0, 0, 0, 1, 4'hF,    9'h10C, 9'h040));
    load(9'h031, ins(OP_TJNZ,   0, 0, 0, 1, 4'hF,    9'h10D, 9'h040));
    load(9'h100, 32'd3);  load(9'h101, 32'd4);  load(9'h102, 32'd3);
    load(9'h103, 32'd1);  load(9'h104, 32'd2);  load(9'h106, 32'd0);
    load(9'h108, 32'h0000ABCD); load(9'h109, 32'hFFFFF000);
    load(9'h10A, 32'h12345FFF); load(9'h10B, 32'd2);
    load(9'h10C, 32'd0);  load(9'h10D, 32'd9);

    chk("rst_pc",  {23'd0, pc}, 32'd0);
    chk("rst_cz",  {30'd0, c, z}, 32'd0);
    chk("rst_strb", {29'd0, m_we, hub_req, alu_run}, 32'd0);
    chk("rst_ra",  {23'd0, m_ra}, 32'd0);
    chk("rst_wawd", m_wd | {23'd0, m_wa}, 32'd0);
    chk("rst_alu", alu_s | alu_d | {26'd0, alu_i} | {31'd0, alu_wc}, 32'd0);

    push(9'h100, 32'd7);
    push(9'h102, 32'd514);
    push(9'h103, 32'hFFFFFFFF);
    push(9'h107, 32'h0000ABCD);
    push(9'h109, 32'hFFFFF006);
    push(9'h10A, 32'h12345E00);
    push(9'h10B, 32'd1);

    start_run();
    tick(4);
    chk("we_clk4", {31'd0, m_we}, 32'd0);
    tick(1);
    chk("we_clk5", {31'd0, m_we}, 32'd1);
    tick(1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) tick(5);
      chk($sformatf("A%0d_pc", k), {23'd0, pc}, {23'd0, exp_pc_a[k]});
      chk($sformatf("A%0d_ra", k), {23'd0, m_ra}, {23'd0, exp_pc_a[k]});
      chk($sformatf("A%0d_cz", k), {30'd0, c, z}, {30'd0, exp_c_a[k], 1'b0});
    end
    ena = 1'b0;
    tick(2);

    // ---------------- program B: wrap, hub stall, disable mid-stall
    load(9'h000, ins(OP_JMPRET, 0, 0, 1, 1, 4'b0101, 9'h110, 9'h1FF));
    load(9'h1FF, ins(OP_SUB,    1, 0, 1, 0, 4'hF,    9'h111, 9'h112));
    load(9'h001, ins(OP_RDLONG, 0, 0, 1, 0, 4'hF,    9'h113, 9'h114));
    load(9'h002, ins(OP_RDLONG, 0, 0, 1, 0, 4'hF,    9'h115, 9'h116));
    load(9'h110, 32'd0);  load(9'h111, 32'd5);  load(9'h112, 32'd5);

    push(9'h110, 32'd1);
    push(9'h111, 32'd0);
    push(9'h113, HUB_DATA);

    start_run();
    tick(1);
    for (int k = 0; k < 3; k++) begin
      tick(5);
      chk($sformatf("B%0d_pc", k), {23'd0, pc}, {23'd0, exp_pc_b[k]});
      chk($sformatf("B%0d_z", k), {31'd0, z}, {31'd0, exp_z_b[k]});
    end

    cyc = 0;
    while (!hub_req && cyc < 20) begin tick(1); cyc++; end
    chk("hub_req_rise", {31'd0, hub_req}, 32'd1);
    cnt = 0;
    while (hub_req && cnt < 40) begin
      cnt++;
      if (cnt == 7) hub_ack = 1'b1;
      tick(1);
      hub_ack = 1'b0;
    end
    chk("hub_req_len", cnt, 32'd7);
    chk("hub_next_ra", {23'd0, m_ra}, 32'd2);
    chk("hub_next_pc", {23'd0, pc}, 32'd2);

    // stray ack during fetch must not satisfy the later stall
    tick(1);
    hub_ack = 1'b1;
    tick(1);
    hub_ack = 1'b0;
    cyc = 0;
    while (!hub_req && cyc < 20) begin tick(1); cyc++; end
    tick(2);
    chk("stall_hold", {31'd0, hub_req}, 32'd1);
    ena = 1'b0;
    tick(1);
    chk("dis_hubreq", {31'd0, hub_req}, 32'd0);
    chk("dis_pc", {23'd0, pc}, 32'd0);
    chk("dis_run", {31'd0, alu_run}, 32'd0);
    ena = 1'b1;
    tick(1);
    chk("reen_ra", {23'd0, m_ra}, 32'd0);
    tick(1);
    chk("reen_run", {31'd0, alu_run}, 32'd1);
    tick(4);
    chk("reen_pc", {23'd0, pc}, 32'd1);
    ena = 1'b0;
    tick(2);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
